mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter MEM_BASE, default 32'h01000000, byte address of first main-memory location.
REQ-002 SHALL have parameter MEM_SIZE, default 32'h00100000, main-memory size in bytes.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports in this order:
- clock  in  1  sole clock; all state on posedge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid at posedge.
- req_write  in  1  0 load, 1 store.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed when high with resp_valid at posedge.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_error  out  1  request rejected, no memory access.
- mem_address  out  32  word-aligned byte address to memory.
- mem_data_in  out  32  write word to memory.
- mem_data_out  in  32  combinational little-endian read word from memory.
- mem_read_write  out  1  0 READ, 1 WRITE; memory writes 4 bytes at posedge when 1.

Function
REQ-004 SHALL implement FSM IDLE, ACCESS, WRITE, RESP; req_ready=1 only in IDLE.
REQ-005 Accept at edge N: error -> RESP at N+1; else -> ACCESS; latch addr, size, unsigned, write, wdata.
REQ-006 Error conditions: req_size=11; addr<MEM_BASE; addr+bytes-1 > MEM_BASE+MEM_SIZE-1 (computed 33-bit, no wrap).
REQ-007 ACCESS: mem_address={addr[31:2],2'b00}; load or sub-word store drives READ; word store drives WRITE with mem_data_in=wdata.
REQ-008 At edge leaving ACCESS: load captures lane data (byte lane addr[1:0], half lane addr[1]) and extends per req_unsigned -> RESP; word store -> RESP; sub-word store captures mem_data_out -> WRITE.
REQ-009 WRITE: mem_read_write=1, mem_data_in = captured word with target lane(s) replaced by wdata[7:0]/[15:0]; -> RESP at next edge.
REQ-010 Latency: load/word store resp_valid from N+2; sub-word store from N+3; error from N+1.
REQ-011 RESP: resp_valid=1, resp_rdata/resp_error stable until resp_ready; -> IDLE on handshake edge; no new request accepted in that same edge.
REQ-012 Outside ACCESS/WRITE: mem_read_write=0, mem_address=MEM_BASE, mem_data_in=0; exactly one WRITE cycle per non-error store, none for loads/errors.
REQ-013 mem_read_write SHALL be decoded from state only (glitch-free, never X).

Reset
REQ-014 reset_n low asynchronously forces IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_read_write=0, mem_address=MEM_BASE, mem_data_in=0.
REQ-015 Reset during ACCESS/WRITE aborts the request; no memory write occurs after reset assertion and no response is produced.

Configuration
REQ-016 MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> error response, no memory access.
REQ-017 MISALIGN_TRAP_EN undefined: misaligned low address bits cleared to natural alignment, request proceeds normally.

Verification
REQ-018 Word 0x01000000=0x8070F0A5; load word there -> resp_rdata=0x8070F0A5, resp_error=0, resp_valid at N+2, mem_read_write never 1.
REQ-019 Load byte 0x01000003 signed -> 0xFFFFFF80; unsigned -> 0x00000080.
REQ-020 Store half 0xBEEF at 0x01000002 -> one READ cycle then one WRITE cycle, mem_data_in=0xBEEFF0A5, memory word 0xBEEFF0A5, resp at N+3.
REQ-021 Half load 0x01000001: with MISALIGN_TRAP_EN -> resp_error=1, rdata 0 at N+1; without -> rdata 0xFFFFF0A5.
REQ-022 Load 0x01100000 and req_size=11 -> resp_error=1, no memory access; resp_ready low 3 cycles -> resp_valid/rdata held, req_ready=0.
REQ-023 reset_n pulsed low during WRITE -> memory word unchanged, all outputs at reset values immediately.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store access controller: bounds-checks a byte/half/word request, then runs a
// read, read-modify-write or word write to main memory. Optional define: MISALIGN_TRAP_EN.
module mem_access_ctrl #(
  parameter logic [31:0] MEM_BASE = 32'h01000000,
  parameter logic [31:0] MEM_SIZE = 32'h00100000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_read_write
);

  localparam logic [1:0]  SZ_BYTE  = 2'b00;
  localparam logic [1:0]  SZ_HALF  = 2'b01;
  localparam logic [1:0]  SZ_WORD  = 2'b10;
  localparam logic [1:0]  SZ_ILL   = 2'b11;
  localparam logic [32:0] MEM_LAST = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE} - 33'd1;
`ifdef MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t      state, state_nxt;
  logic        mem_rw_q, mem_rw_nxt;
  logic        req_err;
  logic [31:0] addr_p0;
  logic [1:0]  size_p0;
  logic        unsigned_p0;
  logic        write_p0;
  logic [31:0] wdata_p0;
  logic [31:0] word_p1;
  logic [31:0] rdata_p1;
  logic        error_p1;

  function automatic logic [32:0] last_byte(input logic [31:0] addr, input logic [1:0] size);
    case (size)
      SZ_BYTE: return {1'b0, addr};
      SZ_HALF: return {1'b0, addr} + 33'd1;
      default: return {1'b0, addr} + 33'd3;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] lo, input logic [1:0] size);
    return TRAP_EN && (((size == SZ_HALF) && lo[0]) || ((size == SZ_WORD) && (lo != 2'b00)));
  endfunction

  function automatic logic [31:0] align_addr(input logic [31:0] addr, input logic [1:0] size);
    case (size)
      SZ_HALF: return {addr[31:1], 1'b0};
      SZ_WORD: return {addr[31:2], 2'b00};
      default: return addr;
    endcase
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] size, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: return uns ? {24'd0, b} : 32'($signed(b));
      SZ_HALF: return uns ? {16'd0, h} : 32'($signed(h));
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] m;
    m = word;
    if (size == SZ_HALF) begin
      if (lane[1]) m[31:16] = wdata[15:0];
      else         m[15:0]  = wdata[15:0];
    end else begin
      case (lane)
        2'd0:    m[7:0]   = wdata[7:0];
        2'd1:    m[15:8]  = wdata[7:0];
        2'd2:    m[23:16] = wdata[7:0];
        default: m[31:24] = wdata[7:0];
      endcase
    end
    return m;
  endfunction

  assign req_err = (req_size == SZ_ILL) || (req_addr < MEM_BASE) ||
                   (last_byte(req_addr, req_size) > MEM_LAST) ||
                   misaligned(req_addr[1:0], req_size);

  // mem_read_write is a flop fed from the next-state decode so it never glitches
  always_comb begin
    state_nxt  = state;
    mem_rw_nxt = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        state_nxt  = req_err ? RESP : ACCESS;
        mem_rw_nxt = !req_err && req_write && (req_size == SZ_WORD);
      end
      ACCESS: begin
        if (write_p0 && (size_p0 != SZ_WORD)) begin
          state_nxt  = WRITE;
          mem_rw_nxt = 1'b1;
        end else begin
          state_nxt = RESP;
        end
      end
      WRITE:   state_nxt = RESP;
      default: if (resp_ready) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      mem_rw_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      mem_rw_q <= mem_rw_nxt;
    end
  end

  // p0: request latched at acceptance
  always_ff @(posedge clock) begin
    if (state == IDLE && req_valid) begin
      addr_p0     <= align_addr(req_addr, req_size);
      size_p0     <= req_size;
      unsigned_p0 <= req_unsigned;
      write_p0    <= req_write;
      wdata_p0    <= req_wdata;
      error_p1    <= req_err;
      rdata_p1    <= '0;
    end
    // p1: memory word captured at the end of ACCESS
    if (state == ACCESS) begin
      word_p1 <= mem_data_out;
      if (!write_p0) rdata_p1 <= extract_load(mem_data_out, addr_p0[1:0], size_p0, unsigned_p0);
    end
  end

  always_comb begin
    req_ready      = (state == IDLE);
    resp_valid     = (state == RESP);
    resp_rdata     = (state == RESP) ? rdata_p1 : '0;
    resp_error     = (state == RESP) ? error_p1 : 1'b0;
    mem_read_write = mem_rw_q;
    mem_address    = ((state == ACCESS) || (state == WRITE)) ? {addr_p0[31:2], 2'b00} : MEM_BASE;
    mem_data_in    = '0;
    if (state == WRITE)      mem_data_in = merge_store(word_p1, addr_p0[1:0], size_p0, wdata_p0);
    else if (mem_rw_q)       mem_data_in = wdata_p0;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vectors plus randomized requests
// compared against an arithmetic reference model and a shadow memory image.
module tb_mem_access_ctrl;

  localparam logic [31:0] BASE = 32'h01000000;
  localparam logic [31:0] SIZE = 32'h00100000;
  localparam logic [31:0] TOP  = BASE + SIZE;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = BASE, req_wdata = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_error;
  logic [31:0] resp_rdata, mem_address, mem_data_in, mem_data_out;
  logic        mem_read_write;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_read_write(mem_read_write)
  );

  always #5 clock = ~clock;

  // Two 1 KiB windows of memory: bottom and top of the legal range
  logic [31:0] mem [512];
  logic [31:0] ref_mem [512];
  logic        seeded = 1'b0;
  int          wr_cnt = 0;
  logic [31:0] last_wr = '0;

  function automatic int widx(input logic [31:0] a);
    if (a < BASE + 32'd1024) return int'((a - BASE) >> 2) & 255;
    return 256 + (int'((a - (TOP - 32'd1024)) >> 2) & 255);
  endfunction

  function automatic logic [31:0] pat(input int i);
    if (i == 0) return 32'h8070F0A5;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  assign mem_data_out = mem[widx(mem_address)];

  always @(posedge clock) begin
    if (!seeded) begin
      for (int i = 0; i < 512; i++) mem[i] <= pat(i);
      seeded <= 1'b1;
    end else if (mem_read_write) begin
      mem[widx(mem_address)] <= mem_data_in;
      wr_cnt  <= wr_cnt + 1;
      last_wr <= mem_data_in;
    end
  end

  // Reference model: decides outcome from the request rules and updates ref_mem
  task automatic model(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic err, output logic [31:0] rdata, output int lat,
                       output int nwr, output int idx);
    int unsigned bytes, sh;
    logic [32:0] endb, limit;
    logic misal;
    logic [31:0] a, word, val, mask;
    bytes = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    endb  = {1'b0, addr} + 33'(bytes) - 33'd1;
    limit = {1'b0, TOP} - 33'd1;
`ifdef MISALIGN_TRAP_EN
    misal = ((sz == 1) && (addr % 2 != 0)) || ((sz == 2) && (addr % 4 != 0));
`else
    misal = 1'b0;
`endif
    err = (sz == 3) || (addr < BASE) || (endb > limit) || misal;
    rdata = '0; lat = 1; nwr = 0; idx = 0;
    if (!err) begin
      a = (sz == 1) ? (addr & ~32'd1) : (sz == 2) ? (addr & ~32'd3) : addr;
      idx = widx(a);
      word = ref_mem[idx];
      sh = (a % 4) * 8;
      if (!w) begin
        val = word >> sh;
        if (sz == 0) begin
          val = val & 32'hFF;
          if (!uns && val >= 32'h80) val = val | 32'hFFFFFF00;
        end else if (sz == 1) begin
          val = val & 32'hFFFF;
          if (!uns && val >= 32'h8000) val = val | 32'hFFFF0000;
        end
        rdata = val; lat = 2;
      end else if (sz == 2) begin
        ref_mem[idx] = wdata; lat = 2; nwr = 1;
      end else begin
        mask = ((sz == 0) ? 32'hFF : 32'hFFFF) << sh;
        ref_mem[idx] = (word & ~mask) | ((wdata << sh) & mask);
        lat = 3; nwr = 1;
      end
    end
  endtask

  task automatic run_req(input string name, input logic w, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input int delay);
    logic err_e; logic [31:0] rd_e; int lat, nwr, idx, cyc, wr0;
    model(w, sz, uns, addr, wdata, err_e, rd_e, lat, nwr, idx);
    wr0 = wr_cnt;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL %s idle_ready got %b want 1", name, req_ready); end
    req_write = w; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (resp_valid !== 1'b1 && cyc < 8) begin @(posedge clock); #1; cyc++; end
    checks++;
    if (cyc != lat) begin errors++; $display("FAIL %s latency got %0d want %0d", name, cyc, lat); end
    checks++;
    if (resp_error !== err_e) begin errors++; $display("FAIL %s resp_error got %b want %b", name, resp_error, err_e); end
    checks++;
    if (resp_rdata !== rd_e) begin errors++; $display("FAIL %s resp_rdata got %h want %h", name, resp_rdata, rd_e); end
    for (int k = 0; k < delay; k++) begin
      @(posedge clock); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== rd_e || resp_error !== err_e || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold v=%b rd=%h e=%b rdy=%b want 1 %h %b 0", name, resp_valid, resp_rdata, resp_error, req_ready, rd_e, err_e);
      end
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL %s handshake v=%b rdy=%b want 0 1", name, resp_valid, req_ready);
    end
    checks++;
    if (wr_cnt - wr0 != nwr) begin errors++; $display("FAIL %s write_cycles got %0d want %0d", name, wr_cnt - wr0, nwr); end
    if (nwr != 0) begin
      checks++;
      if (mem[idx] !== ref_mem[idx]) begin errors++; $display("FAIL %s mem_word got %h want %h", name, mem[idx], ref_mem[idx]); end
      checks++;
      if (last_wr !== ref_mem[idx]) begin errors++; $display("FAIL %s mem_data_in got %h want %h", name, last_wr, ref_mem[idx]); end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_error !== 1'b0) begin
      errors++; $display("FAIL reset_resp rdy=%b v=%b rd=%h e=%b want 1 0 0 0", req_ready, resp_valid, resp_rdata, resp_error);
    end
    checks++;
    if (mem_read_write !== 1'b0 || mem_address !== BASE || mem_data_in !== 32'h0) begin
      errors++; $display("FAIL reset_mem rw=%b addr=%h din=%h want 0 %h 0", mem_read_write, mem_address, mem_data_in, BASE);
    end
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_directed;
    run_req("load_word", 1'b0, 2'b10, 1'b0, 32'h01000000, 32'h0, 0);
    run_req("load_byte_s", 1'b0, 2'b00, 1'b0, 32'h01000003, 32'h0, 1);
    run_req("load_byte_u", 1'b0, 2'b00, 1'b1, 32'h01000003, 32'h0, 0);
    run_req("store_half", 1'b1, 2'b01, 1'b0, 32'h01000002, 32'h0000BEEF, 0);
    checks++;
    if (mem[0] !== 32'hBEEFF0A5) begin errors++; $display("FAIL store_half_word got %h want beeff0a5", mem[0]); end
    run_req("load_half_mis", 1'b0, 2'b01, 1'b0, 32'h01000001, 32'h0, 0);
    run_req("load_oob", 1'b0, 2'b10, 1'b0, 32'h01100000, 32'h0, 0);
    run_req("size_ill", 1'b0, 2'b11, 1'b0, 32'h01000000, 32'h0, 3);
    run_req("store_word", 1'b1, 2'b10, 1'b0, 32'h01000010, 32'h12345678, 0);
    run_req("store_byte_top", 1'b1, 2'b00, 1'b0, TOP - 32'd1, 32'h000000C3, 1);
    run_req("load_below", 1'b0, 2'b00, 1'b0, BASE - 32'd1, 32'h0, 0);
    run_req("word_cross_top", 1'b0, 2'b10, 1'b0, TOP - 32'd2, 32'h0, 0);
  endtask

  task automatic test_back_to_back;
    int cyc;
    run_req("b2b_first", 1'b0, 2'b01, 1'b1, 32'h01000004, 32'h0, 0);
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h01000004;
    req_valid = 1'b1;
    @(posedge clock); #1;
    cyc = 1;
    while (resp_valid !== 1'b1 && cyc < 8) begin @(posedge clock); #1; cyc++; end
    checks++;
    if (cyc != 2) begin errors++; $display("FAIL b2b_latency got %0d want 2", cyc); end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_no_accept_on_handshake rdy=%b v=%b want 1 0", req_ready, resp_valid);
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept_next rdy=%b want 0", req_ready); end
    @(posedge clock); #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== ref_mem[1]) begin
      errors++; $display("FAIL b2b_second v=%b rd=%h want 1 %h", resp_valid, resp_rdata, ref_mem[1]);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_during_write;
    logic [31:0] old;
    int wr0;
    old = mem[2];
    wr0 = wr_cnt;
    req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h01000009;
    req_wdata = 32'h0000005C; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (mem_read_write !== 1'b1) begin errors++; $display("FAIL rst_wr_in_write rw=%b want 1", mem_read_write); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_error !== 1'b0 ||
        mem_read_write !== 1'b0 || mem_address !== BASE || mem_data_in !== 32'h0) begin
      errors++;
      $display("FAIL rst_wr_outputs rdy=%b v=%b rd=%h e=%b rw=%b addr=%h din=%h", req_ready, resp_valid, resp_rdata, resp_error, mem_read_write, mem_address, mem_data_in);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (mem[2] !== old || wr_cnt != wr0) begin
      errors++; $display("FAIL rst_wr_mem got %h writes %0d want %h writes 0", mem[2], wr_cnt - wr0, old);
    end
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_wr_no_resp v=%b rdy=%b want 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_random;
    logic [31:0] addr;
    logic [1:0]  sz;
    int r, s;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r < 5)       addr = BASE + 32'($urandom_range(0, 1023));
      else if (r < 8)  addr = TOP - 32'd1024 + 32'($urandom_range(0, 1023));
      else if (r == 8) addr = BASE - 32'($urandom_range(1, 4));
      else             addr = ($urandom_range(0, 1) == 0) ? TOP + 32'($urandom_range(0, 4)) : 32'hFFFFFFFE;
      s = $urandom_range(0, 9);
      sz = (s < 3) ? 2'b00 : (s < 6) ? 2'b01 : (s < 9) ? 2'b10 : 2'b11;
      run_req("random", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom(),
              $urandom_range(0, 2));
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = pat(i);
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_during_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
